// File: rtl/meas_freq_calc.sv
`default_nettype none
// ============================================================================
//  Module      : meas_freq_calc
//  Description : Consumer of the gated frequency-measurement stage. It
//                captures one 64-bit packed count pair per strobe and computes
//                freq = floor(sig_cnt * REF_CLK_HZ / ref_cnt) with a 64-step
//                restoring divider. The latest result and the sticky status
//                flags are held for the register file.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    REF_CLK_HZ   : reference clock frequency in Hz (32-bit unsigned)
//  Ports
//    clk_i        : system clock
//    rst_n_i      : asynchronous active-low reset
//    meas_valid_i : one-cycle strobe, new measurement on meas_data_i
//    meas_data_i  : {ref_cnt[63:32], sig_cnt[31:0]}
//    clr_i        : one-cycle pulse, clears overrun_o and div_zero_o
//    busy_o       : calculation in progress
//    freq_valid_o : one-cycle pulse when freq_data_o updates
//    freq_data_o  : last computed frequency in Hz
//    div_zero_o   : sticky, a measurement arrived with ref_cnt == 0
//    overrun_o    : sticky, a measurement was dropped while busy
// ============================================================================
module meas_freq_calc #(
    parameter logic [31:0] REF_CLK_HZ = 32'd100_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        meas_valid_i,
    input  logic [63:0] meas_data_i,
    input  logic        clr_i,
    output logic        busy_o,
    output logic        freq_valid_o,
    output logic [63:0] freq_data_o,
    output logic        div_zero_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [63:0] c_ref_hz_64 = {32'd0, REF_CLK_HZ};
    localparam logic [5:0]  c_last_iter = 6'd63;

    state_t      r_state;
    logic [31:0] r_sig;
    logic [31:0] r_ref;
    logic [63:0] r_dividend;
    logic [32:0] r_rem;
    logic [63:0] r_quot;
    logic [5:0]  r_iter;
    logic        r_freq_valid;
    logic [63:0] r_freq_data;
    logic        r_div_zero;
    logic        r_overrun;

    logic [63:0] w_product;
    logic [32:0] w_rem_shift;
    logic [32:0] w_ref_ext;
    logic        w_q_bit;
    logic [32:0] w_rem_next;

    // Both operands are below 2^32, so the 64-bit product is exact.
    assign w_product   = {32'd0, r_sig} * c_ref_hz_64;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The remainder stays
    // below ref_cnt, so its top bit is normally zero; if it were ever set the
    // shifted value would exceed any 32-bit divisor, hence the OR term.
    assign w_rem_shift = {r_rem[31:0], r_dividend[63]};
    assign w_ref_ext   = {1'b0, r_ref};
    assign w_q_bit     = r_rem[32] | (w_rem_shift >= w_ref_ext);
    assign w_rem_next  = w_q_bit ? (w_rem_shift - w_ref_ext) : w_rem_shift;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_sig        <= '0;
            r_ref        <= '0;
            r_dividend   <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_iter       <= '0;
            r_freq_valid <= 1'b0;
            r_freq_data  <= '0;
            r_div_zero   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;

            // Clear first so that a same-cycle set below takes precedence.
            if (clr_i) begin
                r_div_zero <= 1'b0;
                r_overrun  <= 1'b0;
            end

            // Strobes outside IDLE (including the DONE cycle) are dropped.
            if (meas_valid_i && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (meas_valid_i) begin
                        r_sig   <= meas_data_i[31:0];
                        r_ref   <= meas_data_i[63:32];
                        r_state <= LOAD;
                    end
                end

                LOAD: begin
                    if (r_ref == 32'd0) begin
                        r_quot     <= '1;
                        r_div_zero <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_dividend <= w_product;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_iter     <= '0;
                        r_state    <= DIV;
                    end
                end

                DIV: begin
                    r_rem      <= w_rem_next;
                    r_dividend <= {r_dividend[62:0], 1'b0};
                    r_quot     <= {r_quot[62:0], w_q_bit};
                    r_iter     <= r_iter + 6'd1;
                    if (r_iter == c_last_iter) begin
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_freq_data  <= r_quot;
                    r_freq_valid <= 1'b1;
                    r_state      <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (r_state != IDLE);
    assign freq_valid_o = r_freq_valid;
    assign freq_data_o  = r_freq_data;
    assign div_zero_o   = r_div_zero;
    assign overrun_o    = r_overrun;

endmodule
`default_nettype wire

// File: doc/meas_freq_calc.md
Name: meas_freq_calc

Overview:
- Downstream consumer of the gated frequency-measurement stage.
- Captures each 64-bit measurement result, packed as {ref_clk_count[63:32], sig_clk_count[31:0]}, on its one-cycle write strobe.
- Computes measured frequency = floor(sig_cnt * REF_CLK_HZ / ref_cnt) with a multi-cycle restoring divider.
- Holds the latest result and status for the AXI register file.

Parameters:
REF_CLK_HZ, 100000000, reference clock frequency in Hz; unsigned, must fit in 32 bits.

Ports:
clk_i  input  1  system clock.
rst_n_i  input  1  reset, asynchronous, active-low.
meas_valid_i  input  1  one-cycle strobe: new measurement on meas_data_i.
meas_data_i  input  64  {ref_cnt[63:32], sig_cnt[31:0]}.
clr_i  input  1  one-cycle pulse: clears overrun_o and div_zero_o.
busy_o  output  1  high while a calculation is in progress (state != IDLE).
freq_valid_o  output  1  one-cycle pulse when freq_data_o updates.
freq_data_o  output  64  last computed frequency in Hz, integer.
div_zero_o  output  1  sticky: a measurement arrived with ref_cnt == 0.
overrun_o  output  1  sticky: a measurement was dropped because the block was busy.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: state IDLE; all internal registers 0; busy_o 0, freq_valid_o 0, freq_data_o 0, div_zero_o 0, overrun_o 0.
- FSM states: IDLE, LOAD, DIV, DONE.
  - IDLE: on meas_valid_i, latch sig_cnt and ref_cnt, then go to LOAD.
  - LOAD (1 cycle): if ref_cnt == 0, go to DONE with quotient forced to 64'hFFFF_FFFF_FFFF_FFFF and div_zero_o set. Otherwise load dividend = sig_cnt * REF_CLK_HZ (64-bit product, exact, cannot overflow), clear remainder (33 bits) and quotient, iteration counter = 0, go to DIV.
  - DIV (exactly 64 cycles): restoring division, MSB first. Each cycle: shift {remainder, dividend} left 1; if remainder >= ref_cnt, subtract ref_cnt and shift in quotient bit 1, else shift in 0. After iteration 63, go to DONE.
  - DONE (1 cycle): freq_data_o <= quotient; freq_valid_o = 1 for this cycle only; go to IDLE.
- Latency:
  - meas_valid_i sampled at edge T: freq_valid_o is high in the cycle after edge T+66, and freq_data_o is valid from then.
  - ref_cnt == 0 path: freq_valid_o is high after edge T+2.
- freq_data_o holds its value until the next DONE. It never changes mid-calculation.
- Inputs while busy: meas_valid_i in any state other than IDLE is dropped (the in-flight calculation is unaffected) and overrun_o is set. meas_valid_i in the DONE cycle is also dropped. The next accepted strobe is one arriving in IDLE.
- Sticky flags:
  - div_zero_o and overrun_o stay set until clr_i.
  - Same-cycle set and clr_i: set wins.
  - A successful non-zero division does not clear div_zero_o.
- sig_cnt == 0: normal path, result 0.
- Result exceeding 2^64-1 is impossible, since ref_cnt >= 1 and the dividend is < 2^64.
- Reset mid-operation: async assertion aborts immediately to the reset values. No freq_valid_o pulse is produced for the aborted measurement.
- busy_o = (state != IDLE); registered-state decode, no combinational path from inputs.

Test Plan:
- Nominal: reset, then sig=1000, ref=100000, REF_CLK_HZ=1e8 -> freq_valid_o pulses 66 cycles after the strobe, freq_data_o=1000000, flags 0.
- Truncation: sig=3, ref=7 -> freq_data_o=42857142 (floor of 300000000/7).
- Max range: sig=32'hFFFFFFFF, ref=1 -> freq_data_o=429496729500000000, no error flags.
- Zero reference: ref=0, sig=5 -> freq_valid_o 2 cycles after the strobe, freq_data_o=64'hFFFFFFFFFFFFFFFF, div_zero_o=1. clr_i -> div_zero_o=0.
- Overrun: second strobe 10 cycles after the first -> overrun_o=1; first result delivered unchanged; only one freq_valid_o pulse. Then clr_i together with a third dropped strobe -> overrun_o remains 1.
- Reset mid-DIV: assert rst_n_i=0 at cycle 30 of DIV -> all outputs 0 immediately; after release, no freq_valid_o until a new strobe; a new sig=10, ref=10 -> freq_data_o=100000000.
